regfile_bist: RTL and testbench
===============================

// Module: regfile_bist
// PURPOSE
//  Built-in self-test initiator for the 32x32 RV32I register file. It drives the write port
//  (rd_wren/rd_addr/rd_data) and both read ports (rs1/rs2), and checks the returned data.
//  It runs in place of the core datapath during power-on test, muxed onto the regfile
//  ports by the top level. It reports pass/fail, an error count and the first failing address.
// PARAMETERS
//  SEED    32'hA5A5_5A5A  XOR scramble applied to every data pattern
//  ERR_W   8              error counter width; saturates at all-ones
// PORTS
//  clk_i           in   1   core clock
//  rst_ni          in   1   reset, asynchronous, active-low
//  start_i         in   1   begin a test run; sampled only in IDLE or DONE
//  abort_i         in   1   synchronous abort; returns to IDLE
//  rd_wren_o       out  1   regfile write enable
//  rd_addr_o       out  5   regfile write address
//  rd_data_o       out  32  regfile write data
//  rs1_addr_o      out  5   read port 1 address
//  rs2_addr_o      out  5   read port 2 address
//  rs1_data_i      in   32  read port 1 data (combinational from regfile)
//  rs2_data_i      in   32  read port 2 data (combinational from regfile)
//  busy_o          out  1   run in progress
//  done_o          out  1   run complete; held until next start or abort
//  pass_o          out  1   done_o && err_cnt_o==0
//  err_cnt_o       out  ERR_W  number of mismatching port reads in the last run
//  fail_addr_o     out  5   address of the first mismatch (rs1 checked before rs2 in a cycle)
// BEHAVIOUR
//  - Reset (async): state IDLE; every output is 0; internal address counter is 0.
//  - Pattern: pat(a) = SEED ^ {a,~a,a,~a,a,~a,a[4:3]}. Inverse pass uses ~pat(a).
//    Expected value for address 0 is always 32'h0, because x0 is hardwired.
//  - FSM: IDLE -> WR -> RD -> WRI -> RDI -> DONE. Each of WR/RD/WRI/RDI lasts 32 cycles,
//    with addr counter 0..31 wrapping to 0 at each state change.
//  - Start: when start_i=1 in IDLE/DONE at a posedge, the next cycle is WR with addr 0.
//    The same edge clears err_cnt, fail_addr and done. busy_o=1 in WR..RDI.
//  - WR/WRI: rd_wren_o=1, rd_addr_o=addr, rd_data_o=pat(addr) or ~pat(addr).
//    Address 0 is also written to prove the write is ignored.
//  - RD/RDI: rd_wren_o=0, rs1_addr_o=addr, rs2_addr_o=~addr (31-addr).
//    Both data inputs are compared against the expected values at the end-of-cycle posedge.
//  - Outside WR/WRI: rd_wren_o=0 and rd_addr_o/rd_data_o=0. Outside RD/RDI the rs addresses are 0.
//  - Each mismatching port adds 1 to err_cnt (0, 1 or 2 per cycle), saturating.
//    fail_addr latches on the first mismatch of the run only.
//  - Total run: start edge + 128 busy cycles. done_o rises the cycle after the last RDI compare.
//  - start_i while busy: ignored.
//  - abort_i: has priority over start_i. Any state goes to IDLE; busy/done/pass drop to 0.
//    err_cnt/fail_addr hold their values.
//  - Reset mid-run: immediate return to IDLE with all outputs 0. No partial result is retained.
// STRUCTURE
//  - regfile_bist_pkg:
//    - state_e enum {IDLE,WR,RD,WRI,RDI,DONE}
//    - REG_ADDR_W=5, XLEN=32
//    - function bist_pat(addr, inv, seed)
//  - Sub-module regfile_bist_cmp: 2-port compare, err_cnt saturating increment, first-fail capture.
//  - The top level holds the FSM, the addr counter and the port drive.
// TESTING
//  Bench instantiates regfile + regfile_bist; clk period 10.
//  1. Fault-free regfile, start_i pulse -> busy 128 cycles, done_o=1, pass_o=1, err_cnt_o=0.
//  2. Wrapper forces rs1_data_i[0]=1 when rs1_addr==5 -> err_cnt_o=1, fail_addr_o=5, pass_o=0.
//     Exactly one of pat/~pat mismatches.
//  3. Wrapper forces rs2_data_i=0 for rs2_addr==31 -> err_cnt_o=2, fail_addr_o=31.
//     Both passes fail on rs2 at read addr 0.
//  4. Faulty regfile lets x0 store data -> RD cycle 0 rs1 mismatch.
//     Result: err_cnt_o>=2, fail_addr_o=0.
//  5. abort_i at busy cycle 40 -> next cycle IDLE, busy_o=0, done_o=0, rd_wren_o=0.
//     A new start then passes.
//  6. rst_ni low at busy cycle 70 -> all outputs 0 asynchronously.
//     start_i pulses during busy -> ignored, still 128 cycles.

Source files
------------

// File: rtl/regfile_bist_pkg.sv
// Shared types and helpers for the register-file BIST.
//   state_e   : test sequencer states
//   bist_pat  : scrambled data pattern for an address (optionally inverted)
//   bist_exp  : value a healthy regfile returns for that address (x0 reads 0)
package regfile_bist_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    WRI  = 3'd3,
    RDI  = 3'd4,
    DONE = 3'd5
  } state_e;

  // Address replicated with alternating polarity so every data bit is
  // toggled by some address bit, then scrambled by the seed.
  function automatic logic [XLEN-1:0] bist_pat(input logic [REG_ADDR_W-1:0] addr,
                                               input logic                  inv,
                                               input logic [XLEN-1:0]       seed);
    logic [XLEN-1:0] p;
    p = seed ^ {addr, ~addr, addr, ~addr, addr, ~addr, addr[4:3]};
    return inv ? ~p : p;
  endfunction

  // x0 is hardwired, so its read-back is always zero regardless of pattern.
  function automatic logic [XLEN-1:0] bist_exp(input logic [REG_ADDR_W-1:0] addr,
                                               input logic                  inv,
                                               input logic [XLEN-1:0]       seed);
    return (addr == '0) ? '0 : bist_pat(addr, inv, seed);
  endfunction

endpackage

// File: rtl/regfile_bist_if.sv
// Register-file port bundle between the BIST initiator and the regfile.
//   rd_wren/rd_addr/rd_data : write port
//   rs1_addr/rs1_data       : read port 1 (data combinational from regfile)
//   rs2_addr/rs2_data       : read port 2 (data combinational from regfile)
// master = BIST side, slave = regfile side.
interface regfile_bist_if;
  import regfile_bist_pkg::*;

  logic                  rd_wren;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [XLEN-1:0]       rd_data;
  logic [REG_ADDR_W-1:0] rs1_addr;
  logic [REG_ADDR_W-1:0] rs2_addr;
  logic [XLEN-1:0]       rs1_data;
  logic [XLEN-1:0]       rs2_data;

  modport master (output rd_wren, rd_addr, rd_data, rs1_addr, rs2_addr,
                  input  rs1_data, rs2_data);
  modport slave  (input  rd_wren, rd_addr, rd_data, rs1_addr, rs2_addr,
                  output rs1_data, rs2_data);
endinterface

// File: rtl/regfile_bist_cmp.sv
// Two-port read-data checker.
//   clr_i      : clears error count and first-fail address (new run)
//   en_i       : compare this cycle (read phase)
//   inv_i      : expect inverted pattern
//   rs*_addr_i : addresses presented on the read ports this cycle
//   rs*_data_i : data returned by the regfile
//   err_cnt_o  : saturating mismatch count (0..2 added per cycle)
//   fail_addr_o: address of the first mismatch of the run, rs1 before rs2
module regfile_bist_cmp
  import regfile_bist_pkg::*;
#(
  parameter logic [XLEN-1:0] SEED  = 32'hA5A5_5A5A,
  parameter int              ERR_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic                  inv_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic [XLEN-1:0]       rs1_data_i,
  input  logic [XLEN-1:0]       rs2_data_i,
  output logic [ERR_W-1:0]      err_cnt_o,
  output logic [REG_ADDR_W-1:0] fail_addr_o
);

  logic           miss1, miss2;
  logic [1:0]     inc;
  logic [ERR_W:0] sum;
  logic [ERR_W-1:0] err_nxt;

  always_comb begin
    miss1   = en_i && (rs1_data_i !== bist_exp(rs1_addr_i, inv_i, SEED));
    miss2   = en_i && (rs2_data_i !== bist_exp(rs2_addr_i, inv_i, SEED));
    inc     = {1'b0, miss1} + {1'b0, miss2};
    sum     = {1'b0, err_cnt_o} + {{(ERR_W-1){1'b0}}, inc};
    err_nxt = sum[ERR_W] ? '1 : sum[ERR_W-1:0];
  end

  // err_cnt never returns to zero within a run, so zero marks "no fail yet".
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_o   <= '0;
      fail_addr_o <= '0;
    end else if (clr_i) begin
      err_cnt_o   <= '0;
      fail_addr_o <= '0;
    end else if (miss1 || miss2) begin
      err_cnt_o <= err_nxt;
      if (err_cnt_o == '0) fail_addr_o <= miss1 ? rs1_addr_i : rs2_addr_i;
    end
  end

endmodule

// File: rtl/regfile_bist.sv
// Power-on BIST initiator for the 32x32 RV32I register file.
// Writes pat(a) to every address, reads it back on both ports (rs2 walks
// the address space in reverse), then repeats with ~pat(a).
//   clk_i, rst_ni   : clock, async active-low reset
//   start_i         : begin a run (honoured in IDLE/DONE only)
//   abort_i         : return to IDLE; results so far are kept
//   rf              : regfile port bundle (master side)
//   busy_o/done_o   : run in progress / run complete (held)
//   pass_o          : done with zero errors
//   err_cnt_o       : mismatching port reads in the last run
//   fail_addr_o     : first failing address
module regfile_bist
  import regfile_bist_pkg::*;
#(
  parameter logic [XLEN-1:0] SEED  = 32'hA5A5_5A5A,
  parameter int              ERR_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  regfile_bist_if.master        rf,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ERR_W-1:0]      err_cnt_o,
  output logic [REG_ADDR_W-1:0] fail_addr_o
);

  state_e                state_q, state_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic                  start_acc;
  logic                  wr_d, rd_d;

  assign start_acc = !abort_i && start_i && (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (abort_i) begin
      state_d = IDLE;
      addr_d  = '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start_i) begin
          state_d = WR;
          addr_d  = '0;
        end
        WR, RD, WRI, RDI: begin
          addr_d = addr_q + 5'd1;   // wraps to 0 on the phase change
          if (addr_q == 5'd31) begin
            case (state_q)
              WR:      state_d = RD;
              RD:      state_d = WRI;
              WRI:     state_d = RDI;
              default: state_d = DONE;
            endcase
          end
        end
        default: begin
          state_d = IDLE;
          addr_d  = '0;
        end
      endcase
    end
    wr_d = (state_d == WR) || (state_d == WRI);
    rd_d = (state_d == RD) || (state_d == RDI);
  end

  // Port drive is registered from the next state so it lines up with state_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rf.rd_wren  <= 1'b0;
      rf.rd_addr  <= '0;
      rf.rd_data  <= '0;
      rf.rs1_addr <= '0;
      rf.rs2_addr <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rf.rd_wren  <= wr_d;
      rf.rd_addr  <= wr_d ? addr_d : '0;
      rf.rd_data  <= wr_d ? bist_pat(addr_d, state_d == WRI, SEED) : '0;
      rf.rs1_addr <= rd_d ? addr_d : '0;
      rf.rs2_addr <= rd_d ? ~addr_d : '0;
      busy_o      <= wr_d || rd_d;
      done_o      <= (state_d == DONE);
    end
  end

  // The compare on an aborting edge is dropped: the run is being abandoned.
  regfile_bist_cmp #(.SEED(SEED), .ERR_W(ERR_W)) u_cmp (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (start_acc),
    .en_i       (!abort_i && (state_q == RD || state_q == RDI)),
    .inv_i      (state_q == RDI),
    .rs1_addr_i (rf.rs1_addr),
    .rs2_addr_i (rf.rs2_addr),
    .rs1_data_i (rf.rs1_data),
    .rs2_data_i (rf.rs2_data),
    .err_cnt_o  (err_cnt_o),
    .fail_addr_o(fail_addr_o)
  );

  assign pass_o = done_o && (err_cnt_o == '0);

endmodule

// File: tb/tb_regfile_bist.sv
// Bench: behavioural regfile with injectable faults driven by regfile_bist.
module tb_regfile_bist;

  localparam logic [31:0] SEED = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic        busy, done, pass;
  logic [7:0]  err_cnt;
  logic [4:0]  fail_addr;
  int          fault;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic [7:0] err;
    logic [4:0] fail;
    logic       pass;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem [32];

  regfile_bist_if rf_bus();

  regfile_bist #(.SEED(SEED), .ERR_W(8)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .abort_i    (abort),
    .rf         (rf_bus),
    .busy_o     (busy),
    .done_o     (done),
    .pass_o     (pass),
    .err_cnt_o  (err_cnt),
    .fail_addr_o(fail_addr)
  );

  always #5 clk = ~clk;

  // Regfile model. fault: 1 rs1 bit0 stuck-1 at addr 5, 2 rs2 reads 0 at
  // addr 31, 3 x0 stores data.
  always @(posedge clk)
    if (rf_bus.rd_wren && (rf_bus.rd_addr != 5'd0 || fault == 3))
      mem[rf_bus.rd_addr] <= rf_bus.rd_data;

  always_comb begin
    rf_bus.rs1_data = (rf_bus.rs1_addr == 5'd0 && fault != 3) ? 32'h0 : mem[rf_bus.rs1_addr];
    rf_bus.rs2_data = (rf_bus.rs2_addr == 5'd0 && fault != 3) ? 32'h0 : mem[rf_bus.rs2_addr];
    if (fault == 1 && rf_bus.rs1_addr == 5'd5)  rf_bus.rs1_data[0] = 1'b1;
    if (fault == 2 && rf_bus.rs2_addr == 5'd31) rf_bus.rs2_data = 32'h0;
  end

  function automatic logic [31:0] pat(input logic [4:0] a, input logic inv);
    logic [31:0] p;
    p = SEED ^ {a, ~a, a, ~a, a, ~a, a[4:3]};
    return inv ? ~p : p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_err"},  32'(err_cnt), 32'd0);
    chk({tag, "_fail"}, 32'(fail_addr), 32'd0);
    chk({tag, "_wr"},   {rf_bus.rd_wren, 26'd0, rf_bus.rd_addr}, 32'd0);
    chk({tag, "_wdata"}, rf_bus.rd_data, 32'd0);
    chk({tag, "_rsaddr"}, {22'd0, rf_bus.rs1_addr, rf_bus.rs2_addr}, 32'd0);
  endtask

  // Full run: pushes the expected result, counts busy cycles, spot-checks the
  // port drive, and pops/compares when done rises.
  task automatic do_run(input int f, input logic [7:0] e_err, input logic [4:0] e_fail,
                        input logic e_pass, input bit pulse);
    int   cyc;
    exp_t e;
    fault = f;
    sb.push_back('{e_err, e_fail, e_pass});
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      if (cyc == 0) begin
        chk("wr0_en",   32'(rf_bus.rd_wren), 32'd1);
        chk("wr0_data", rf_bus.rd_data, pat(5'd0, 1'b0));
      end
      if (cyc == 33)
        chk("rd1_addrs", {22'd0, rf_bus.rs1_addr, rf_bus.rs2_addr}, {22'd0, 5'd1, 5'd30});
      if (cyc == 70)
        chk("wri6", {rf_bus.rd_wren, 26'd0, rf_bus.rd_addr}, {1'b1, 26'd0, 5'd6});
      if (cyc == 71)
        chk("wri7_data", rf_bus.rd_data, pat(5'd7, 1'b1));
      start = (pulse && (cyc == 10 || cyc == 100)) ? 1'b1 : 1'b0;
      step();
      cyc++;
    end
    start = 1'b0;
    chk("busy_cycles", 32'(cyc), 32'd128);
    chk("done", 32'(done), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("err_cnt",   32'(err_cnt),   32'(e.err));
      chk("fail_addr", 32'(fail_addr), 32'(e.fail));
      chk("pass",      32'(pass),      32'(e.pass));
    end
    step();
    chk("done_hold", {30'd0, done, busy}, {30'd0, 1'b1, 1'b0});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    fault = 0;
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset");
    #10 rst_n = 1'b1;

    do_run(0, 8'd0,  5'd0,  1'b1, 1'b0);   // fault-free
    do_run(1, 8'd1,  5'd5,  1'b0, 1'b0);   // rs1 bit0 stuck at addr 5
    do_run(2, 8'd2,  5'd31, 1'b0, 1'b0);   // rs2 zero at addr 31
    do_run(3, 8'd4,  5'd0,  1'b0, 1'b0);   // x0 writable

    // Abort at busy cycle 40; the addr-5 miss has already been counted.
    fault = 1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (40) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_state", {28'd0, busy, done, pass, rf_bus.rd_wren}, 32'd0);
    chk("abort_err_hold",  32'(err_cnt),   32'd1);
    chk("abort_fail_hold", 32'(fail_addr), 32'd5);
    do_run(0, 8'd0, 5'd0, 1'b1, 1'b0);

    // Async reset at busy cycle 70 wipes the partial result.
    fault = 1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (70) step();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

    // start pulses while busy are ignored
    do_run(0, 8'd0, 5'd0, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
